// File: rtl/flash_arb_pkg.sv
// Shared types and sizing helpers for the Flash bus arbiter.
// The phase counter holds 0..BYTE_CYCLES-1 and is sized from the access time.
package flash_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CPU_HI   = 3'd1,
        ST_CPU_LO   = 3'd2,
        ST_CPU_BYTE = 3'd3,
        ST_DISK     = 3'd4,
        ST_ACK      = 3'd5
    } arb_state_e;

    localparam int BYTE_CYCLES_DEFAULT = 1;

    function automatic int phase_cnt_width(input int byte_cycles);
        return (byte_cycles < 1) ? 1 : $clog2(byte_cycles + 1);
    endfunction

endpackage

// File: rtl/flash_bus_arbiter.sv
// Shares the 8-bit Flash bus between CPU word/byte reads and disk byte reads.
// All pin-facing outputs and acks are registered; a losing disk request wins next time.
module flash_bus_arbiter
    import flash_arb_pkg::*;
#(
    parameter int BYTE_CYCLES = BYTE_CYCLES_DEFAULT
) (
    input  logic        clk8,
    input  logic        reset,
    input  logic        cpuReq,
    input  logic [20:0] cpuWordAddr,
    input  logic        cpuByteMode,
    input  logic        cpuA0,
    output logic        cpuAck,
    output logic [15:0] cpuData,
    input  logic        diskReq,
    input  logic [21:0] diskByteAddr,
    output logic        diskAck,
    output logic [7:0]  diskData,
    output logic [21:0] flashAddr,
    input  logic [7:0]  flashData,
    output logic        _flashCE,
    output logic        _flashOE
);

    localparam int              PW         = phase_cnt_width(BYTE_CYCLES);
    localparam logic [PW-1:0]   PHASE_LAST = PW'(BYTE_CYCLES - 1);
    localparam logic [PW-1:0]   PHASE_ONE  = PW'(1);

    arb_state_e     state_q, state_d;
    logic [PW-1:0]  phase_q, phase_d;
    logic [20:0]    cpu_addr_q, cpu_addr_d;
    logic           cpu_a0_q, cpu_a0_d;
    logic [21:0]    disk_addr_q, disk_addr_d;
    logic           disk_sel_q, disk_sel_d;
    logic           disk_waited_q, disk_waited_d;
    logic [15:0]    cpu_data_q, cpu_data_d;
    logic [7:0]     disk_data_q, disk_data_d;
    logic           cpu_ack_q, cpu_ack_d;
    logic           disk_ack_q, disk_ack_d;
    logic [21:0]    flash_addr_q, flash_addr_d;
    logic           flash_ce_n_q, flash_ce_n_d;
    logic           flash_oe_n_q, flash_oe_n_d;
    logic           phase_last_s;
    logic           bus_busy_s;

    assign phase_last_s = (phase_q == PHASE_LAST);

    // Next-state: arbitration in IDLE, byte-phase sequencing and data capture.
    always_comb begin
        state_d       = state_q;
        phase_d       = '0;
        cpu_addr_d    = cpu_addr_q;
        cpu_a0_d      = cpu_a0_q;
        disk_addr_d   = disk_addr_q;
        disk_sel_d    = disk_sel_q;
        disk_waited_d = disk_waited_q;
        cpu_data_d    = cpu_data_q;
        disk_data_d   = disk_data_q;

        case (state_q)
            ST_IDLE: begin
                // A disk request that already lost once takes priority over the CPU.
                if (cpuReq && !(diskReq && disk_waited_q)) begin
                    cpu_addr_d    = cpuWordAddr;
                    cpu_a0_d      = cpuA0;
                    disk_sel_d    = 1'b0;
                    disk_waited_d = disk_waited_q | diskReq;
                    state_d       = cpuByteMode ? ST_CPU_BYTE : ST_CPU_HI;
                end else if (diskReq) begin
                    disk_addr_d   = diskByteAddr;
                    disk_sel_d    = 1'b1;
                    disk_waited_d = 1'b0;
                    state_d       = ST_DISK;
                end else begin
                    state_d       = ST_IDLE;
                end
            end
            ST_CPU_HI: begin
                if (phase_last_s) begin
                    cpu_data_d[15:8] = flashData;
                    state_d          = ST_CPU_LO;
                end else begin
                    phase_d          = phase_q + PHASE_ONE;
                end
            end
            ST_CPU_LO: begin
                if (phase_last_s) begin
                    cpu_data_d[7:0] = flashData;
                    state_d         = ST_ACK;
                end else begin
                    phase_d         = phase_q + PHASE_ONE;
                end
            end
            ST_CPU_BYTE: begin
                if (phase_last_s) begin
                    cpu_data_d = {8'h00, flashData};
                    state_d    = ST_ACK;
                end else begin
                    phase_d    = phase_q + PHASE_ONE;
                end
            end
            ST_DISK: begin
                if (phase_last_s) begin
                    disk_data_d = flashData;
                    state_d     = ST_ACK;
                end else begin
                    phase_d     = phase_q + PHASE_ONE;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state so pins and acks come straight off flops.
    always_comb begin
        flash_addr_d = flash_addr_q;
        bus_busy_s   = 1'b0;
        case (state_d)
            ST_CPU_HI: begin
                flash_addr_d = {cpu_addr_d, 1'b0};
                bus_busy_s   = 1'b1;
            end
            ST_CPU_LO: begin
                flash_addr_d = {cpu_addr_d, 1'b1};
                bus_busy_s   = 1'b1;
            end
            ST_CPU_BYTE: begin
                flash_addr_d = {cpu_addr_d, cpu_a0_d};
                bus_busy_s   = 1'b1;
            end
            ST_DISK: begin
                flash_addr_d = disk_addr_d;
                bus_busy_s   = 1'b1;
            end
            default: begin
                flash_addr_d = flash_addr_q;
                bus_busy_s   = 1'b0;
            end
        endcase
        flash_ce_n_d = ~bus_busy_s;
        flash_oe_n_d = ~bus_busy_s;
        cpu_ack_d    = (state_d == ST_ACK) && !disk_sel_d;
        disk_ack_d   = (state_d == ST_ACK) && disk_sel_d;
    end

    // State and output registers; reset abandons any transfer without an ack.
    always_ff @(posedge clk8) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            phase_q       <= '0;
            cpu_addr_q    <= 21'h0;
            cpu_a0_q      <= 1'b0;
            disk_addr_q   <= 22'h0;
            disk_sel_q    <= 1'b0;
            disk_waited_q <= 1'b0;
            cpu_data_q    <= 16'h0000;
            disk_data_q   <= 8'h00;
            cpu_ack_q     <= 1'b0;
            disk_ack_q    <= 1'b0;
            flash_addr_q  <= 22'h0;
            flash_ce_n_q  <= 1'b1;
            flash_oe_n_q  <= 1'b1;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            cpu_addr_q    <= cpu_addr_d;
            cpu_a0_q      <= cpu_a0_d;
            disk_addr_q   <= disk_addr_d;
            disk_sel_q    <= disk_sel_d;
            disk_waited_q <= disk_waited_d;
            cpu_data_q    <= cpu_data_d;
            disk_data_q   <= disk_data_d;
            cpu_ack_q     <= cpu_ack_d;
            disk_ack_q    <= disk_ack_d;
            flash_addr_q  <= flash_addr_d;
            flash_ce_n_q  <= flash_ce_n_d;
            flash_oe_n_q  <= flash_oe_n_d;
        end
    end

    assign cpuAck    = cpu_ack_q;
    assign cpuData   = cpu_data_q;
    assign diskAck   = disk_ack_q;
    assign diskData  = disk_data_q;
    assign flashAddr = flash_addr_q;
    assign _flashCE  = flash_ce_n_q;
    assign _flashOE  = flash_oe_n_q;

endmodule
